stop_it_game_fsm: RTL and testbench

// - Round controller for Stop-It; directly upstream of game_counter on the clk_4_i domain.
// - Drives the counter's enable and its active-low reload, and latches a 5-bit target per round.
// - Compares the live count against the target when the player presses stop.
// - Tracks score and lives, and signals hit/miss/won/lost to the display stage.

---
 rtl/stop_it_pkg.sv | 38 +++
 rtl/stop_it_game_fsm_if.sv | 43 ++++
 rtl/stop_it_flash_timer.sv | 37 +++
 rtl/stop_it_game_fsm.sv | 155 +++++++++++++++
 tb/tb_stop_it_game_fsm.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/stop_it_pkg.sv
// -----------------------------------------------------------------------------
// stop_it_pkg
// Shared types and constants for the Stop-It round controller.
//   state_e     : round controller states
//   COUNT_W     : width of the game counter value
//   COUNT_MAX   : value the game counter reloads to (31)
//   SCORE_W     : width of the hit score
//   LIVES_W     : width of the remaining-lives count
//   sat_inc_score / sat_dec_lives : saturating update helpers
// -----------------------------------------------------------------------------
package stop_it_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_RUN  = 3'd2,
        ST_HIT  = 3'd3,
        ST_MISS = 3'd4,
        ST_WON  = 3'd5,
        ST_LOST = 3'd6
    } state_e;

    localparam int              COUNT_W   = 5;
    localparam logic [4:0]      COUNT_MAX = 5'h1f;
    localparam int              SCORE_W   = 4;
    localparam int              LIVES_W   = 3;

    // Score never wraps past 15 back to 0.
    function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
    endfunction

    // Lives never wrap below 0.
    function automatic logic [LIVES_W-1:0] sat_dec_lives(input logic [LIVES_W-1:0] v);
        return (v == '0) ? v : v - LIVES_W'(1);
    endfunction

endpackage

// File: rtl/stop_it_game_fsm_if.sv
// -----------------------------------------------------------------------------
// stop_it_game_fsm_if
// Bundles the round controller's game-side signals.
//   start_i, stop_i      : player requests (clean levels)
//   target_i             : random target from the generator
//   count_i              : live count from game_counter
//   counter_en_o         : enable to game_counter
//   counter_rst_no       : active-low reload to game_counter (reloads 31)
//   target_o, score_o, lives_o, hit_o, miss_o, won_o, lost_o : display outputs
// Modports:
//   slave  : the round controller itself
//   master : the environment (player inputs, counter, display)
// -----------------------------------------------------------------------------
interface stop_it_game_fsm_if;
    import stop_it_pkg::*;

    logic               start_i;
    logic               stop_i;
    logic [COUNT_W-1:0] target_i;
    logic [COUNT_W-1:0] count_i;
    logic               counter_en_o;
    logic               counter_rst_no;
    logic [COUNT_W-1:0] target_o;
    logic [SCORE_W-1:0] score_o;
    logic [LIVES_W-1:0] lives_o;
    logic               hit_o;
    logic               miss_o;
    logic               won_o;
    logic               lost_o;

    modport slave (
        input  start_i, stop_i, target_i, count_i,
        output counter_en_o, counter_rst_no, target_o, score_o, lives_o,
               hit_o, miss_o, won_o, lost_o
    );

    modport master (
        output start_i, stop_i, target_i, count_i,
        input  counter_en_o, counter_rst_no, target_o, score_o, lives_o,
               hit_o, miss_o, won_o, lost_o
    );

endinterface

// File: rtl/stop_it_flash_timer.sv
// -----------------------------------------------------------------------------
// stop_it_flash_timer
// Loadable down-counter that times how long a HIT/MISS result is shown.
//   clk_4_i : 4 Hz game clock
//   rst_ni  : asynchronous active-low reset (count returns to 0)
//   load_i  : load FLASH_CYCLES-1; asserted on the edge entering HIT/MISS
//   done_o  : high on the last flash cycle (count == 0)
// Loading FLASH_CYCLES-1 means the result state lasts exactly FLASH_CYCLES
// cycles: the owner leaves on the edge that ends the done_o cycle.
// -----------------------------------------------------------------------------
module stop_it_flash_timer #(
    parameter int FLASH_CYCLES = 8
) (
    input  logic clk_4_i,
    input  logic rst_ni,
    input  logic load_i,
    output logic done_o
);

    localparam int          TW       = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam logic [TW-1:0] LOAD_VAL = TW'(FLASH_CYCLES - 1);

    logic [TW-1:0] count_reg;

    always_ff @(posedge clk_4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_reg <= '0;
        end else if (load_i) begin
            count_reg <= LOAD_VAL;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - TW'(1);
        end
    end

    assign done_o = (count_reg == '0);

endmodule

// File: rtl/stop_it_game_fsm.sv
// -----------------------------------------------------------------------------
// stop_it_game_fsm
// Round controller for Stop-It, sitting directly upstream of game_counter.
// Each round reloads the counter to 31, latches a target, lets the counter
// run down, and scores the player's stop press against the target.
//   clk_4_i : 4 Hz game clock
//   rst_ni  : asynchronous active-low reset
//   game    : stop_it_game_fsm_if.slave (inputs, counter control, display)
// Parameters:
//   WIN_SCORE    : hits needed to win (1..15)
//   LIVES        : misses allowed before loss (1..7)
//   FLASH_CYCLES : cycles a HIT/MISS result is shown (>=1)
// Result indicators are registered decodes of the next state, so a stop
// sampled at edge N shows hit_o/miss_o from edge N. counter_en_o and
// counter_rst_no are combinational so the count freezes on the stop cycle
// itself and the counter reloads for the single ARM cycle.
// -----------------------------------------------------------------------------
module stop_it_game_fsm
    import stop_it_pkg::*;
#(
    parameter int WIN_SCORE    = 9,
    parameter int LIVES        = 3,
    parameter int FLASH_CYCLES = 8
) (
    input  logic              clk_4_i,
    input  logic              rst_ni,
    stop_it_game_fsm_if.slave game
);

    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [LIVES_W-1:0] LIVES_VAL = LIVES_W'(LIVES);

    state_e             state_reg,  state_next;
    logic [SCORE_W-1:0] score_reg,  score_next;
    logic [LIVES_W-1:0] lives_reg,  lives_next;
    logic [COUNT_W-1:0] target_reg, target_next;
    logic               hit_reg, miss_reg, won_reg, lost_reg;
    logic               flash_load;
    logic               flash_done;

    stop_it_flash_timer #(
        .FLASH_CYCLES (FLASH_CYCLES)
    ) u_flash_timer (
        .clk_4_i (clk_4_i),
        .rst_ni  (rst_ni),
        .load_i  (flash_load),
        .done_o  (flash_done)
    );

    always_comb begin
        state_next  = state_reg;
        score_next  = score_reg;
        lives_next  = lives_reg;
        target_next = target_reg;
        flash_load  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (game.start_i) begin
                    state_next = ST_ARM;
                    score_next = '0;
                    lives_next = LIVES_VAL;
                end
            end

            ST_ARM: begin
                // Counter is held in reload this cycle; the target is
                // captured here and nowhere else.
                target_next = game.target_i;
                state_next  = ST_RUN;
            end

            ST_RUN: begin
                // A stop press is judged before the timeout, so stopping at
                // count 0 with target 0 scores a hit.
                if (game.stop_i) begin
                    flash_load = 1'b1;
                    if (game.count_i == target_reg) begin
                        state_next = ST_HIT;
                        score_next = sat_inc_score(score_reg);
                    end else begin
                        state_next = ST_MISS;
                        lives_next = sat_dec_lives(lives_reg);
                    end
                end else if (game.count_i == '0) begin
                    flash_load = 1'b1;
                    state_next = ST_MISS;
                    lives_next = sat_dec_lives(lives_reg);
                end
            end

            ST_HIT: begin
                if (flash_done) begin
                    state_next = (score_reg == WIN_VAL) ? ST_WON : ST_ARM;
                end
            end

            ST_MISS: begin
                if (flash_done) begin
                    state_next = (lives_reg == '0) ? ST_LOST : ST_ARM;
                end
            end

            ST_WON, ST_LOST: begin
                if (game.start_i) begin
                    state_next = ST_ARM;
                    score_next = '0;
                    lives_next = LIVES_VAL;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= ST_IDLE;
            score_reg  <= '0;
            lives_reg  <= LIVES_VAL;
            target_reg <= '0;
            hit_reg    <= 1'b0;
            miss_reg   <= 1'b0;
            won_reg    <= 1'b0;
            lost_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            score_reg  <= score_next;
            lives_reg  <= lives_next;
            target_reg <= target_next;
            // Decoding the next state keeps the indicators registered while
            // aligning them with the state they describe.
            hit_reg    <= (state_next == ST_HIT);
            miss_reg   <= (state_next == ST_MISS);
            won_reg    <= (state_next == ST_WON);
            lost_reg   <= (state_next == ST_LOST);
        end
    end

    // The count must never wrap 0 -> 31, so enable drops at zero as well as
    // on the stop cycle.
    assign game.counter_en_o   = (state_reg == ST_RUN) && !game.stop_i && (game.count_i != '0);
    assign game.counter_rst_no = rst_ni && (state_reg != ST_ARM);

    assign game.target_o = target_reg;
    assign game.score_o  = score_reg;
    assign game.lives_o  = lives_reg;
    assign game.hit_o    = hit_reg;
    assign game.miss_o   = miss_reg;
    assign game.won_o    = won_reg;
    assign game.lost_o   = lost_reg;

endmodule

// File: tb/tb_stop_it_game_fsm.sv
// -----------------------------------------------------------------------------
// tb_stop_it_game_fsm
// Drives the round controller together with a behavioural game_counter
// (down-counter, asynchronous reload to 31 while counter_rst_no is low).
// Result transactions are queued when the stop/timeout stimulus is applied
// and popped when hit_o/miss_o appears.
// -----------------------------------------------------------------------------
module tb_stop_it_game_fsm;
    import stop_it_pkg::*;

    typedef struct packed {
        logic       is_hit;
        logic [3:0] score;
        logic [2:0] lives;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] model_count;
    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stop_it_game_fsm_if game_if();

    stop_it_game_fsm #(
        .WIN_SCORE    (2),
        .LIVES        (3),
        .FLASH_CYCLES (8)
    ) dut (
        .clk_4_i (clk),
        .rst_ni  (rst_n),
        .game    (game_if)
    );

    // game_counter stand-in
    always @(posedge clk or negedge game_if.counter_rst_no) begin
        if (!game_if.counter_rst_no) model_count <= COUNT_MAX;
        else if (game_if.counter_en_o) model_count <= model_count - 5'd1;
    end
    assign game_if.count_i = model_count;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_count(input logic [4:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (game_if.count_i == v) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Called on the first cycle a result is visible; returns on the first
    // cycle it is gone.
    task automatic wait_flash_end(output int len);
        len = 0;
        for (int i = 0; i < 40; i++) begin
            if (!(game_if.hit_o || game_if.miss_o)) break;
            len++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if (game_if.score_o !== 4'd0 || game_if.lives_o !== 3'd3) begin errors++; $display("FAIL reset_score_lives got=%0d/%0d want=0/3", game_if.score_o, game_if.lives_o); end
        checks++; if (game_if.counter_en_o !== 1'b0 || game_if.counter_rst_no !== 1'b1) begin errors++; $display("FAIL reset_idle_ctrl got en=%b rstn=%b want en=0 rstn=1", game_if.counter_en_o, game_if.counter_rst_no); end
        checks++; if ({game_if.hit_o, game_if.miss_o, game_if.won_o, game_if.lost_o} !== 4'b0 || game_if.target_o !== 5'd0) begin errors++; $display("FAIL reset_flags got=%b tgt=%0d want=0000 tgt=0", {game_if.hit_o, game_if.miss_o, game_if.won_o, game_if.lost_o}, game_if.target_o); end
        // start a round, then reset between edges mid-RUN
        game_if.target_i = 5'd13; game_if.start_i = 1'b1; tick(); game_if.start_i = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (game_if.counter_rst_no !== 1'b0 || game_if.counter_en_o !== 1'b0) begin errors++; $display("FAIL async_reset_ctrl got rstn=%b en=%b want 0/0", game_if.counter_rst_no, game_if.counter_en_o); end
        checks++; if (game_if.count_i !== COUNT_MAX || game_if.target_o !== 5'd0 || game_if.lives_o !== 3'd3) begin errors++; $display("FAIL async_reset_state got cnt=%0d tgt=%0d lives=%0d want 31/0/3", game_if.count_i, game_if.target_o, game_if.lives_o); end
        tick(); rst_n = 1'b1; tick();
        checks++; if (game_if.counter_rst_no !== 1'b1) begin errors++; $display("FAIL reset_stays_idle got rstn=%b want 1", game_if.counter_rst_no); end
        $display("txn reset done");
    endtask

    task automatic test_hit();
        bit ok; exp_t e; int len; bit frozen_bad;
        game_if.target_i = 5'd20; game_if.start_i = 1'b1; tick(); game_if.start_i = 1'b0;
        checks++; if (game_if.counter_rst_no !== 1'b0 || game_if.count_i !== COUNT_MAX) begin errors++; $display("FAIL arm_reload got rstn=%b cnt=%0d want 0/31", game_if.counter_rst_no, game_if.count_i); end
        tick();
        checks++; if (game_if.counter_rst_no !== 1'b1 || game_if.target_o !== 5'd20 || game_if.count_i !== COUNT_MAX) begin errors++; $display("FAIL run_entry got rstn=%b tgt=%0d cnt=%0d want 1/20/31", game_if.counter_rst_no, game_if.target_o, game_if.count_i); end
        wait_count(5'd20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hit_wait got=timeout want=count20"); end
        game_if.stop_i = 1'b1; sb.push_back('{1'b1, 4'd1, 3'd3});
        tick(); game_if.stop_i = 1'b0;
        checks++; if (game_if.hit_o !== 1'b1 || game_if.miss_o !== 1'b0) begin errors++; $display("FAIL hit_flag got hit=%b miss=%b want 1/0", game_if.hit_o, game_if.miss_o); end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if (game_if.score_o !== e.score || game_if.lives_o !== e.lives) begin errors++; $display("FAIL hit_score got=%0d/%0d want=%0d/%0d", game_if.score_o, game_if.lives_o, e.score, e.lives); end
            $display("txn hit score=%0d lives=%0d", game_if.score_o, game_if.lives_o);
        end
        frozen_bad = 1'b0; len = 0;
        for (int i = 0; i < 40; i++) begin
            if (!game_if.hit_o) break;
            if (game_if.count_i !== 5'd20) frozen_bad = 1'b1;
            len++;
            tick();
        end
        checks++; if (len != 8) begin errors++; $display("FAIL hit_len got=%0d want=8", len); end
        checks++; if (frozen_bad) begin errors++; $display("FAIL hit_frozen got=moving want=20"); end
        checks++; if (game_if.counter_rst_no !== 1'b0 || game_if.count_i !== COUNT_MAX) begin errors++; $display("FAIL hit_rearm got rstn=%b cnt=%0d want 0/31", game_if.counter_rst_no, game_if.count_i); end
    endtask

    task automatic test_miss_loss();
        bit ok; exp_t e; int len;
        tick();
        for (int k = 0; k < 3; k++) begin
            wait_count(5'd19, ok);
            checks++; if (!ok) begin errors++; $display("FAIL miss_wait%0d got=timeout want=count19", k); end
            game_if.stop_i = 1'b1; sb.push_back('{1'b0, 4'd1, 3'(2 - k)});
            tick(); game_if.stop_i = 1'b0;
            checks++; if (game_if.miss_o !== 1'b1 || game_if.hit_o !== 1'b0) begin errors++; $display("FAIL miss_flag%0d got miss=%b hit=%b want 1/0", k, game_if.miss_o, game_if.hit_o); end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++; if (game_if.lives_o !== e.lives || game_if.score_o !== e.score) begin errors++; $display("FAIL miss_lives%0d got=%0d/%0d want=%0d/%0d", k, game_if.lives_o, game_if.score_o, e.lives, e.score); end
                $display("txn miss score=%0d lives=%0d", game_if.score_o, game_if.lives_o);
            end
            wait_flash_end(len);
            checks++; if (len != 8) begin errors++; $display("FAIL miss_len%0d got=%0d want=8", k, len); end
            if (k < 2) begin
                checks++; if (game_if.counter_rst_no !== 1'b0 || game_if.lost_o !== 1'b0) begin errors++; $display("FAIL miss_rearm%0d got rstn=%b lost=%b want 0/0", k, game_if.counter_rst_no, game_if.lost_o); end
                tick();
            end
        end
        checks++; if (game_if.lost_o !== 1'b1) begin errors++; $display("FAIL lost_flag got=%b want=1", game_if.lost_o); end
        for (int i = 0; i < 3; i++) begin
            game_if.stop_i = 1'b1; tick(); game_if.stop_i = 1'b0; tick();
        end
        checks++; if (game_if.lost_o !== 1'b1 || game_if.lives_o !== 3'd0 || game_if.counter_rst_no !== 1'b1) begin errors++; $display("FAIL lost_hold got lost=%b lives=%0d rstn=%b want 1/0/1", game_if.lost_o, game_if.lives_o, game_if.counter_rst_no); end
        game_if.start_i = 1'b1; tick(); game_if.start_i = 1'b0;
        checks++; if (game_if.counter_rst_no !== 1'b0 || game_if.lives_o !== 3'd3 || game_if.score_o !== 4'd0 || game_if.lost_o !== 1'b0) begin errors++; $display("FAIL lost_restart got rstn=%b lives=%0d score=%0d lost=%b want 0/3/0/0", game_if.counter_rst_no, game_if.lives_o, game_if.score_o, game_if.lost_o); end
        $display("txn restart after loss");
    endtask

    task automatic test_timeout();
        exp_t e; int len; bit found, bad_en, bad_wrap, seen_lower;
        tick();
        sb.push_back('{1'b0, 4'd0, 3'd2});
        found = 1'b0; bad_en = 1'b0; bad_wrap = 1'b0; seen_lower = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (game_if.count_i == 5'd0) begin
                found = 1'b1;
                break;
            end
            if (game_if.counter_en_o !== 1'b1) bad_en = 1'b1;
            if (game_if.count_i != COUNT_MAX) seen_lower = 1'b1;
            else if (seen_lower) bad_wrap = 1'b1;
            tick();
        end
        checks++; if (!found || game_if.counter_en_o !== 1'b0) begin errors++; $display("FAIL timeout_en_zero got found=%b en=%b want 1/0", found, game_if.counter_en_o); end
        checks++; if (bad_en || bad_wrap) begin errors++; $display("FAIL timeout_run got bad_en=%b wrap=%b want 0/0", bad_en, bad_wrap); end
        tick();
        checks++; if (game_if.miss_o !== 1'b1 || game_if.count_i !== 5'd0) begin errors++; $display("FAIL timeout_miss got miss=%b cnt=%0d want 1/0", game_if.miss_o, game_if.count_i); end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if (game_if.lives_o !== e.lives || game_if.score_o !== e.score) begin errors++; $display("FAIL timeout_lives got=%0d/%0d want=%0d/%0d", game_if.lives_o, game_if.score_o, e.lives, e.score); end
            $display("txn timeout miss score=%0d lives=%0d", game_if.score_o, game_if.lives_o);
        end
        wait_flash_end(len);
        checks++; if (game_if.counter_rst_no !== 1'b0) begin errors++; $display("FAIL timeout_rearm got rstn=%b want 0", game_if.counter_rst_no); end
    endtask

    task automatic test_win();
        bit ok; exp_t e; int len;
        game_if.target_i = 5'd7;
        tick();
        checks++; if (game_if.target_o !== 5'd7) begin errors++; $display("FAIL win_target1 got=%0d want=7", game_if.target_o); end
        wait_count(5'd7, ok);
        game_if.stop_i = 1'b1; sb.push_back('{1'b1, 4'd1, 3'd2});
        tick(); game_if.stop_i = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if (!ok || game_if.hit_o !== 1'b1 || game_if.score_o !== e.score || game_if.lives_o !== e.lives) begin errors++; $display("FAIL win_hit1 got hit=%b score=%0d lives=%0d want 1/%0d/%0d", game_if.hit_o, game_if.score_o, game_if.lives_o, e.score, e.lives); end
            $display("txn hit score=%0d lives=%0d", game_if.score_o, game_if.lives_o);
        end
        wait_flash_end(len);
        checks++; if (game_if.counter_rst_no !== 1'b0 || game_if.won_o !== 1'b0) begin errors++; $display("FAIL win_not_yet got rstn=%b won=%b want 0/0", game_if.counter_rst_no, game_if.won_o); end
        game_if.target_i = 5'd12;
        tick();
        wait_count(5'd12, ok);
        game_if.stop_i = 1'b1; sb.push_back('{1'b1, 4'd2, 3'd2});
        tick(); game_if.stop_i = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if (!ok || game_if.hit_o !== 1'b1 || game_if.score_o !== e.score || game_if.lives_o !== e.lives) begin errors++; $display("FAIL win_hit2 got hit=%b score=%0d lives=%0d want 1/%0d/%0d", game_if.hit_o, game_if.score_o, game_if.lives_o, e.score, e.lives); end
            $display("txn hit score=%0d lives=%0d", game_if.score_o, game_if.lives_o);
        end
        wait_flash_end(len);
        checks++; if (game_if.won_o !== 1'b1) begin errors++; $display("FAIL won_flag got=%b want=1", game_if.won_o); end
        tick(); tick(); tick();
        checks++; if (game_if.won_o !== 1'b1 || game_if.score_o !== 4'd2 || game_if.target_o !== 5'd12) begin errors++; $display("FAIL won_hold got won=%b score=%0d tgt=%0d want 1/2/12", game_if.won_o, game_if.score_o, game_if.target_o); end
        game_if.start_i = 1'b1; tick(); game_if.start_i = 1'b0;
        checks++; if (game_if.score_o !== 4'd0 || game_if.won_o !== 1'b0 || game_if.counter_rst_no !== 1'b0 || game_if.lives_o !== 3'd3) begin errors++; $display("FAIL won_restart got score=%0d won=%b rstn=%b lives=%0d want 0/0/0/3", game_if.score_o, game_if.won_o, game_if.counter_rst_no, game_if.lives_o); end
        $display("txn restart after win");
    endtask

    task automatic test_corner();
        bit ok; exp_t e; int len;
        game_if.target_i = 5'd0;
        tick();
        checks++; if (game_if.counter_rst_no !== 1'b1 || game_if.target_o !== 5'd0) begin errors++; $display("FAIL single_arm got rstn=%b tgt=%0d want 1/0", game_if.counter_rst_no, game_if.target_o); end
        wait_count(5'd25, ok);
        game_if.start_i = 1'b1; tick(); game_if.start_i = 1'b0;
        checks++; if (!ok || game_if.counter_rst_no !== 1'b1 || game_if.count_i !== 5'd24) begin errors++; $display("FAIL start_in_run got rstn=%b cnt=%0d want 1/24", game_if.counter_rst_no, game_if.count_i); end
        game_if.target_i = 5'd9; tick();
        checks++; if (game_if.target_o !== 5'd0) begin errors++; $display("FAIL target_mid_run got=%0d want=0", game_if.target_o); end
        wait_count(5'd0, ok);
        game_if.stop_i = 1'b1; sb.push_back('{1'b1, 4'd1, 3'd3});
        tick(); game_if.stop_i = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if (!ok || game_if.hit_o !== 1'b1 || game_if.miss_o !== 1'b0 || game_if.score_o !== e.score || game_if.lives_o !== e.lives) begin errors++; $display("FAIL stop_at_zero got hit=%b miss=%b score=%0d lives=%0d want 1/0/%0d/%0d", game_if.hit_o, game_if.miss_o, game_if.score_o, game_if.lives_o, e.score, e.lives); end
            $display("txn hit at zero score=%0d lives=%0d", game_if.score_o, game_if.lives_o);
        end
        wait_flash_end(len);
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (game_if.counter_rst_no !== 1'b0 || game_if.count_i !== COUNT_MAX || game_if.score_o !== 4'd0 || game_if.hit_o !== 1'b0) begin errors++; $display("FAIL midround_reset got rstn=%b cnt=%0d score=%0d hit=%b want 0/31/0/0", game_if.counter_rst_no, game_if.count_i, game_if.score_o, game_if.hit_o); end
        tick(); rst_n = 1'b1; tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        game_if.start_i  = 1'b0;
        game_if.stop_i   = 1'b0;
        game_if.target_i = 5'd0;
        test_reset();
        test_hit();
        test_miss_loss();
        test_timeout();
        test_win();
        test_corner();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
